// File: rtl/mod_counter_divider_if.sv
// mod_counter_divider_if: control and status bundle for mod_counter_divider.
// The grayOut signal exists only when MODCNT_GRAY_EN is defined.
interface mod_counter_divider_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] loadValue;
  logic [WIDTH-1:0] counterOut;
  logic             terminal;
  logic             divOut;
`ifdef MODCNT_GRAY_EN
  logic [WIDTH-1:0] grayOut;

  modport master (
    output enable, up, load, loadValue,
    input  counterOut, terminal, divOut, grayOut
  );

  modport slave (
    input  enable, up, load, loadValue,
    output counterOut, terminal, divOut, grayOut
  );
`else
  modport master (
    output enable, up, load, loadValue,
    input  counterOut, terminal, divOut
  );

  modport slave (
    input  enable, up, load, loadValue,
    output counterOut, terminal, divOut
  );
`endif
endinterface

// File: rtl/mod_counter_divider.sv
// mod_counter_divider: up/down modulo-MODULUS counter with parallel load,
// a one-cycle terminal pulse after every wrap and a divide-by-2*MODULUS
// square wave that toggles on each wrap.
// Optional feature macro: MODCNT_GRAY_EN adds a registered Gray-coded count.
module mod_counter_divider #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  mod_counter_divider_if.slave bus
);

  // Reject moduli that cannot be represented or make no sense.
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("mod_counter_divider: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             term_q, term_d;
  logic             div_q, div_d;
  logic             wrap;

  // Next count: load beats enable; only the count boundaries are wraps.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (bus.load) begin
      cnt_d = ({1'b0, bus.loadValue} < MOD_EXT) ? bus.loadValue : MAX_CNT;
    end else if (bus.enable) begin
      if (bus.up) begin
        if (cnt_q == MAX_CNT) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = MAX_CNT;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
    term_d = wrap;
    div_d  = div_q ^ wrap;
  end

  // State registers; reset clears everything and drops any pending wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
      div_q  <= div_d;
    end
  end

  assign bus.counterOut = cnt_q;
  assign bus.terminal   = term_q;
  assign bus.divOut     = div_q;

`ifdef MODCNT_GRAY_EN
  logic [WIDTH-1:0] gray_q;

  // Gray code derived from the next count so it tracks counterOut exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= cnt_d ^ (cnt_d >> 1);
    end
  end

  assign bus.grayOut = gray_q;
`endif

endmodule

// File: tb/tb_mod_counter_divider.sv
// tb_mod_counter_divider: directed bench for mod_counter_divider.
// Main DUT uses WIDTH=4/MODULUS=10; a second WIDTH=3/MODULUS=8 instance
// covers natural binary rollover. Gray checks follow MODCNT_GRAY_EN.
module tb_mod_counter_divider;

  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  mod_counter_divider_if #(.WIDTH(4)) bus ();
  mod_counter_divider_if #(.WIDTH(3)) b8  ();

  mod_counter_divider #(.WIDTH(4), .MODULUS(10)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  mod_counter_divider #(.WIDTH(3), .MODULUS(8)) u_dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (b8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input int c, input int t, input int d);
    check({tag, "_cnt"},  32'(bus.counterOut), 32'(c));
    check({tag, "_term"}, 32'(bus.terminal),   32'(t));
    check({tag, "_div"},  32'(bus.divOut),     32'(d));
`ifdef MODCNT_GRAY_EN
    check({tag, "_gray"}, 32'(bus.grayOut),    32'(c ^ (c >> 1)));
`endif
  endtask

  initial begin
    int gray3 [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int e;
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.up        = 1'b1;
    bus.load      = 1'b0;
    bus.loadValue = '0;
    b8.enable     = 1'b1;
    b8.up         = 1'b1;
    b8.load       = 1'b0;
    b8.loadValue  = '0;

    // Reset state
    tick();
    tick();
    expect_state("reset", 0, 0, 0);
    check("reset_w3_cnt", 32'(b8.counterOut), 0);

    // Up counting over 25 edges: wraps after edges 10 and 20
    reset      = 1'b0;
    bus.enable = 1'b1;
    bus.up     = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      tick();
      expect_state("up", k % 10, (k % 10 == 0) ? 1 : 0, (k >= 10 && k < 20) ? 1 : 0);
      if (k <= 9) begin
        check("w3_cnt",  32'(b8.counterOut), 32'(k % 8));
        check("w3_term", 32'(b8.terminal),   (k == 8) ? 1 : 0);
        check("w3_div",  32'(b8.divOut),     (k >= 8) ? 1 : 0);
`ifdef MODCNT_GRAY_EN
        check("w3_gray", 32'(b8.grayOut),    32'(gray3[k % 8]));
`endif
      end
    end

    // Load to 0 (not a wrap), then count down through the boundary
    bus.load      = 1'b1;
    bus.loadValue = 4'd0;
    tick();
    expect_state("load0", 0, 0, 0);
    bus.load = 1'b0;
    bus.up   = 1'b0;
    tick();
    expect_state("down_wrap", 9, 1, 1);
    tick();
    expect_state("down_8", 8, 0, 1);

    // Out-of-range load clamps; load on a would-be wrap suppresses it
    bus.load      = 1'b1;
    bus.loadValue = 4'd13;
    bus.enable    = 1'b0;
    tick();
    expect_state("load_clamp", 9, 0, 1);
    bus.loadValue = 4'd9;
    bus.enable    = 1'b1;
    bus.up        = 1'b1;
    tick();
    expect_state("load_supp", 9, 0, 1);

    // Hold, then an up wrap, then hold drops terminal
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    tick();
    expect_state("hold", 9, 0, 1);
    bus.enable = 1'b1;
    tick();
    expect_state("up_wrap", 0, 1, 0);
    bus.enable = 1'b0;
    tick();
    expect_state("hold_term", 0, 0, 0);

    // Reset overrides load and enable, clearing divOut
    bus.up     = 1'b0;
    bus.enable = 1'b1;
    tick();
    expect_state("down_wrap2", 9, 1, 1);
    bus.enable    = 1'b0;
    bus.load      = 1'b1;
    bus.loadValue = 4'd7;
    tick();
    expect_state("load7", 7, 0, 1);
    reset         = 1'b1;
    bus.loadValue = 4'd3;
    bus.enable    = 1'b1;
    bus.up        = 1'b1;
    tick();
    expect_state("rst_over", 0, 0, 0);
    reset    = 1'b0;
    bus.load = 1'b0;
    tick();
    expect_state("resume", 1, 0, 0);

    // Reset on a pending wrap discards it
    bus.load      = 1'b1;
    bus.loadValue = 4'd9;
    tick();
    expect_state("load9", 9, 0, 0);
    bus.load = 1'b0;
    reset    = 1'b1;
    tick();
    expect_state("rst_wrap", 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_state("rst_resume", 1, 0, 0);

    // Alternating enable: one step every other edge, divOut period 40
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      bus.enable = (n % 2 == 1);
      tick();
      e = (n + 1) / 2;
      expect_state("alt", e % 10, ((n % 2 == 1) && (e % 10 == 0)) ? 1 : 0, (e / 10) % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter_divider.md
MOD_COUNTER_DIVIDER -- requirements
Module: mod_counter_divider

Interface
REQ-001 Parameter: WIDTH, default 4, counter register width in bits.
REQ-002 Parameter: MODULUS, default 10, count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  reset, synchronous and active-high.
REQ-005 Port: enable  input  1  count enable; 1 = advance one step this edge.
REQ-006 Port: up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 Port: load  input  1  synchronous parallel load strobe.
REQ-008 Port: loadValue  input  WIDTH  value applied on load.
REQ-009 Port: counterOut  output  WIDTH  registered count.
REQ-010 Port: terminal  output  1  registered one-cycle pulse following each wrap.
REQ-011 Port: divOut  output  1  registered divided clock-enable square wave.
REQ-012 Port: grayOut  output  WIDTH  registered Gray-coded count; present only when MODCNT_GRAY_EN is defined.

Function
REQ-013 Edge priority SHALL be reset > load > enable > hold.
REQ-014 With load=1, counterOut SHALL take loadValue if loadValue < MODULUS, else MODULUS-1; load acts regardless of enable or up.
REQ-015 With load=0, enable=1, up=1: counterOut SHALL increment, and wrap from MODULUS-1 to 0.
REQ-016 With load=0, enable=1, up=0: counterOut SHALL decrement, and wrap from 0 to MODULUS-1.
REQ-017 With load=0, enable=0: counterOut, divOut SHALL hold; terminal SHALL be 0 next cycle.
REQ-018 A wrap SHALL be only the REQ-015/REQ-016 boundary transitions; a load onto 0 or MODULUS-1 is not a wrap.
REQ-019 terminal SHALL be 1 in exactly the cycle after the edge on which a wrap occurred, else 0.
REQ-020 divOut SHALL toggle on every wrap edge; with enable held high, period = 2*MODULUS cycles, 50% duty.
REQ-021 load SHALL NOT alter divOut; a load coincident with a would-be wrap suppresses that wrap (no terminal, no toggle).
REQ-022 Direction change SHALL take effect on the next enabled edge; no skipped or repeated values.
REQ-023 Arithmetic SHALL be WIDTH bits; MODULUS = 2^WIDTH SHALL behave identically to natural binary rollover.
REQ-024 MODULUS outside 2..2^WIDTH SHALL cause an elaboration-time error.
REQ-025 Latency: counterOut reflects an edge's operation in the same cycle after that edge; terminal/divOut likewise, no extra pipeline stage.

Reset
REQ-026 reset=1 at an edge SHALL set counterOut=0, terminal=0, divOut=0, grayOut=0, overriding load and enable.
REQ-027 Reset asserted mid-count SHALL discard any pending wrap; counting resumes from 0 on the first enabled edge after release.

Configuration
REQ-028 Macro MODCNT_GRAY_EN defined: grayOut port and register SHALL exist, with grayOut == counterOut ^ (counterOut >> 1) in every cycle, including after load and reset.
REQ-029 Macro MODCNT_GRAY_EN undefined: grayOut port and all Gray logic SHALL be absent; remaining behaviour unchanged.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-030 Reset, enable=1, up=1 for 25 cycles -> counterOut 0..9,0..9,0..4; terminal high in cycle after each 9->0; divOut toggles 0->1->0 at those edges.
REQ-031 Count to 0, then up=0, enable=1 -> counterOut 0->9->8; terminal pulse after 0->9; divOut toggles once.
REQ-032 load=1, loadValue=13 -> counterOut=9, no terminal; loadValue=9 with enable=1, up=1 on the same edge -> counterOut=9, no terminal, divOut unchanged.
REQ-033 Counting at 7, assert reset and load together for one edge -> all outputs 0; next enabled edge counterOut=1.
REQ-034 WIDTH=3, MODULUS=8, enable=1, up=1 -> counterOut 0..7,0, terminal after 7->0; MODCNT_GRAY_EN defined -> grayOut 0,1,3,2,6,7,5,4,0.
REQ-035 enable toggled 1/0 alternately -> counterOut advances every other cycle; divOut period 40 cycles.
